// File: rtl/axi_stream_fifo_fwft_sc_pkg.sv
// Shared types and sizing/threshold helpers for the single-clock FWFT FIFO.
package axi_stream_fifo_pkg;

  typedef enum logic {
    S_IDLE_EMPTY = 1'b0,
    S_HOLD       = 1'b1
  } pf_state_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy must represent DEPTH itself, hence one bit wider than a pointer.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic almost_full_hit(input int unsigned occ, input int unsigned depth,
                                           input int unsigned offset);
    return occ >= (depth - offset);
  endfunction

  function automatic logic almost_empty_hit(input int unsigned occ, input int unsigned offset);
    return occ <= offset;
  endfunction

endpackage

// File: rtl/axi_stream_fifo_fwft_sc_if.sv
// FIFO port set: write side DI/WREN/FULL, read side DO/RDEN/EMPTY, plus flags and pointers.
interface axi_stream_fifo_fwft_sc_if #(
  parameter int DATA_WIDTH = 72,
  parameter int DEPTH      = 512
);
  localparam int AW = axi_stream_fifo_pkg::ptr_width(DEPTH);

  logic [DATA_WIDTH-1:0] DI;
  logic                  WREN;
  logic                  FULL;
  logic                  ALMOSTFULL;
  logic                  WRERR;
  logic [AW-1:0]         WRCOUNT;
  logic [DATA_WIDTH-1:0] DO;
  logic                  RDEN;
  logic                  EMPTY;
  logic                  ALMOSTEMPTY;
  logic                  RDERR;
  logic [AW-1:0]         RDCOUNT;

  modport master (
    output DI, WREN, RDEN,
    input  FULL, ALMOSTFULL, WRERR, WRCOUNT, DO, EMPTY, ALMOSTEMPTY, RDERR, RDCOUNT
  );

  modport slave (
    input  DI, WREN, RDEN,
    output FULL, ALMOSTFULL, WRERR, WRCOUNT, DO, EMPTY, ALMOSTEMPTY, RDERR, RDCOUNT
  );

endinterface

// File: rtl/axi_stream_fifo_fwft_sc_sdp_ram_sync.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module sdp_ram_sync #(
  parameter  int DATA_WIDTH = 72,
  parameter  int DEPTH      = 512,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // The read register doubles as the FWFT head register, so it is reset to a known zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/axi_stream_fifo_fwft_sc.sv
// Single-clock first-word-fall-through FIFO: RAM plus its read register acting as the head word.
//   state        | meaning
//   S_IDLE_EMPTY | read register holds no live word, EMPTY=1
//   S_HOLD       | read register holds the head word shown on DO
module axi_stream_fifo_fwft_sc
  import axi_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH          = 72,
  parameter int DEPTH               = 512,
  parameter int ALMOST_EMPTY_OFFSET = 16,
  parameter int ALMOST_FULL_OFFSET  = 16
) (
  input logic                     aclk,
  input logic                     aresetn,
  axi_stream_fifo_fwft_sc_if.slave fifo
);

  localparam int              AW      = ptr_width(DEPTH);
  localparam int              OW      = occ_width(DEPTH);
  localparam logic [OW-1:0]   DEPTH_O = OW'(DEPTH);

  pf_state_t             r_state;
  pf_state_t             w_state_next;
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW-1:0]         r_rdcount;
  logic [AW-1:0]         r_ram_cnt;
  logic [OW-1:0]         r_occ;
  logic [OW-1:0]         w_occ_next;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_wrerr;
  logic                  r_rderr;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_load;
  logic                  w_ram_nonempty;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_wr_acc       = fifo.WREN && !r_full;
  assign w_rd_acc       = fifo.RDEN && (r_state == S_HOLD);
  assign w_ram_nonempty = (r_ram_cnt != '0);
  assign w_occ_next     = r_occ + OW'(w_wr_acc) - OW'(w_rd_acc);

  // r_ram_cnt only counts words committed on earlier edges, so a prefetch never
  // reads the address being written on the same edge.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE_EMPTY: begin
        if (w_ram_nonempty) begin
          w_load       = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_rd_acc) begin
          if (w_ram_nonempty) w_load = 1'b1;
          else                w_state_next = S_IDLE_EMPTY;
        end
      end
      default: w_state_next = S_IDLE_EMPTY;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_IDLE_EMPTY;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_rdcount <= '0;
      r_ram_cnt <= '0;
      r_occ     <= '0;
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_aempty  <= 1'b1;
      r_wrerr   <= 1'b0;
      r_rderr   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      if (w_wr_acc) r_wptr    <= r_wptr + AW'(1);
      if (w_load)   r_rptr    <= r_rptr + AW'(1);
      if (w_rd_acc) r_rdcount <= r_rdcount + AW'(1);
      r_ram_cnt <= r_ram_cnt + AW'(w_wr_acc) - AW'(w_load);
      r_occ     <= w_occ_next;
      r_full    <= (w_occ_next == DEPTH_O);
      r_afull   <= almost_full_hit(32'(w_occ_next), DEPTH, ALMOST_FULL_OFFSET);
      r_aempty  <= almost_empty_hit(32'(w_occ_next), ALMOST_EMPTY_OFFSET);
      r_wrerr   <= fifo.WREN && r_full;
      r_rderr   <= fifo.RDEN && (r_state == S_IDLE_EMPTY);
    end
  end

  sdp_ram_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr),
    .i_wdata (fifo.DI),
    .i_re    (w_load),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  assign fifo.DO          = w_rdata;
  assign fifo.EMPTY       = (r_state == S_IDLE_EMPTY);
  assign fifo.FULL        = r_full;
  assign fifo.ALMOSTFULL  = r_afull;
  assign fifo.ALMOSTEMPTY = r_aempty;
  assign fifo.WRERR       = r_wrerr;
  assign fifo.RDERR       = r_rderr;
  assign fifo.WRCOUNT     = r_wptr;
  assign fifo.RDCOUNT     = r_rdcount;

endmodule

// File: tb/tb_axi_stream_fifo_fwft_sc.sv
// Randomized bench for the FWFT FIFO against a queue-based reference model.
module tb_axi_stream_fifo_fwft_sc;

  localparam int DW    = 72;
  localparam int DEPTH = 512;
  localparam int AEO   = 16;
  localparam int AFO   = 16;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  always #5 aclk = ~aclk;

  axi_stream_fifo_fwft_sc_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus();

  axi_stream_fifo_fwft_sc #(
    .DATA_WIDTH          (DW),
    .DEPTH               (DEPTH),
    .ALMOST_EMPTY_OFFSET (AEO),
    .ALMOST_FULL_OFFSET  (AFO)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .fifo    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of stored words and whether the head is presented on DO.
  logic [DW-1:0] q[$];
  bit            m_vis   = 1'b0;
  logic [DW-1:0] m_do    = '0;
  bit            m_wrerr = 1'b0;
  bit            m_rderr = 1'b0;
  int            m_wrc   = 0;
  int            m_rdc   = 0;
  int            t_sz;
  bit            t_wr;
  bit            t_pop;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      q.delete();
      m_vis = 1'b0; m_do = '0; m_wrerr = 1'b0; m_rderr = 1'b0;
      m_wrc = 0; m_rdc = 0;
    end else begin
      t_sz    = q.size();
      t_wr    = bus.WREN && (t_sz != DEPTH);
      t_pop   = bus.RDEN && m_vis;
      m_wrerr = bus.WREN && (t_sz == DEPTH);
      m_rderr = bus.RDEN && !m_vis;
      if (t_pop) begin
        void'(q.pop_front());
        m_rdc++;
      end
      if (t_wr) begin
        q.push_back(bus.DI);
        m_wrc++;
      end
      // A word appears on DO only once it was stored before this edge.
      m_vis = (t_sz - int'(t_pop)) >= 1;
      if (m_vis) m_do = q[0];
    end
  end

  always @(negedge aclk) begin
    chk("EMPTY",       128'(bus.EMPTY),       128'(!m_vis));
    chk("DO",          128'(bus.DO),          128'(m_do));
    chk("FULL",        128'(bus.FULL),        128'(q.size() == DEPTH));
    chk("ALMOSTFULL",  128'(bus.ALMOSTFULL),  128'(q.size() >= DEPTH - AFO));
    chk("ALMOSTEMPTY", 128'(bus.ALMOSTEMPTY), 128'(q.size() <= AEO));
    chk("WRERR",       128'(bus.WRERR),       128'(m_wrerr));
    chk("RDERR",       128'(bus.RDERR),       128'(m_rderr));
    chk("WRCOUNT",     128'(bus.WRCOUNT),     128'(m_wrc % DEPTH));
    chk("RDCOUNT",     128'(bus.RDCOUNT),     128'(m_rdc % DEPTH));
  end

  function automatic logic [DW-1:0] rnd();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  task automatic cyc(input bit wr, input logic [DW-1:0] d, input bit rd);
    bus.WREN = wr;
    bus.DI   = d;
    bus.RDEN = rd;
    @(posedge aclk);
    #1;
    bus.WREN = 1'b0;
    bus.RDEN = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit wr, rd;
    int pw, pr;
    bus.WREN = 1'b0;
    bus.RDEN = 1'b0;
    bus.DI   = '0;
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;
    @(posedge aclk);
    #1;

    chk("rst_EMPTY", 128'(bus.EMPTY), 128'(1));
    chk("rst_DO",    128'(bus.DO),    128'(0));
    chk("rst_AE",    128'(bus.ALMOSTEMPTY), 128'(1));
    chk("rst_FULL",  128'(bus.FULL),  128'(0));

    // Basic FWFT latency and ordering
    cyc(1'b1, 72'hA1, 1'b0);
    chk("t1_empty_1edge", 128'(bus.EMPTY), 128'(1));
    cyc(1'b1, 72'hA2, 1'b0);
    chk("t1_empty_2edge", 128'(bus.EMPTY), 128'(0));
    chk("t1_do_a1",       128'(bus.DO),    128'(72'hA1));
    cyc(1'b1, 72'hA3, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("t1_do_a2", 128'(bus.DO), 128'(72'hA2));
    cyc(1'b0, '0, 1'b1);
    chk("t1_do_a3", 128'(bus.DO), 128'(72'hA3));
    cyc(1'b0, '0, 1'b1);
    chk("t1_empty_end", 128'(bus.EMPTY), 128'(1));
    chk("t1_do_hold",   128'(bus.DO),    128'(72'hA3));

    // Read underflow, then simultaneous write+read into empty
    cyc(1'b0, '0, 1'b1);
    chk("t4_rderr",  128'(bus.RDERR), 128'(1));
    chk("t4_do",     128'(bus.DO),    128'(72'hA3));
    cyc(1'b1, 72'hB4, 1'b1);
    chk("t4_rderr2", 128'(bus.RDERR), 128'(1));
    chk("t4_empty",  128'(bus.EMPTY), 128'(1));
    cyc(1'b0, '0, 1'b0);
    chk("t4_rderr_clr", 128'(bus.RDERR), 128'(0));
    chk("t4_do_b4",     128'(bus.DO),    128'(72'hB4));
    chk("t4_wrcount",   128'(bus.WRCOUNT), 128'(4));
    cyc(1'b0, '0, 1'b1);
    chk("t4_rdcount",   128'(bus.RDCOUNT), 128'(4));
    chk("t4_empty_end", 128'(bus.EMPTY),   128'(1));

    // Fill to full, overflow
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, rnd(), 1'b0);
      if (i == DEPTH - AFO - 1) chk("t2_af_below", 128'(bus.ALMOSTFULL), 128'(0));
      if (i == DEPTH - AFO)     chk("t2_af_at",    128'(bus.ALMOSTFULL), 128'(1));
      if (i == DEPTH - 1)       chk("t2_full_511", 128'(bus.FULL),       128'(0));
      if (i == DEPTH)           chk("t2_full_512", 128'(bus.FULL),       128'(1));
    end
    cyc(1'b1, rnd(), 1'b0);
    chk("t2_wrerr",     128'(bus.WRERR), 128'(1));
    chk("t2_occ_model", 128'(q.size()),  128'(512));
    cyc(1'b0, '0, 1'b0);
    chk("t2_wrerr_clr", 128'(bus.WRERR), 128'(0));

    // Write+read while full
    cyc(1'b1, rnd(), 1'b1);
    chk("t3_full",      128'(bus.FULL),  128'(0));
    chk("t3_wrerr",     128'(bus.WRERR), 128'(1));
    chk("t3_occ_model", 128'(q.size()),  128'(511));

    // Drain to 8, then steady streaming
    for (int i = 0; i < 700; i++) begin
      if (q.size() <= 8) break;
      cyc(1'b0, '0, 1'b1);
    end
    chk("t5_occ_start", 128'(q.size()), 128'(8));
    for (int i = 0; i < 2000; i++) cyc(1'b1, rnd(), 1'b1);
    chk("t5_occ_end", 128'(q.size()),        128'(8));
    chk("t5_ae",      128'(bus.ALMOSTEMPTY), 128'(1));
    chk("t5_empty",   128'(bus.EMPTY),       128'(0));

    // Randomized traffic with shifting bias to reach both full and empty
    for (int i = 0; i < 3000; i++) begin
      case (i / 750)
        0:       begin pw = 90; pr = 30; end
        1:       begin pw = 30; pr = 90; end
        2:       begin pw = 50; pr = 50; end
        default: begin pw = 95; pr = 10; end
      endcase
      wr = ($urandom_range(99) < pw);
      rd = ($urandom_range(99) < pr);
      cyc(wr, rnd(), rd);
    end

    // Reach occupancy 100, then asynchronous reset mid-stream
    for (int i = 0; i < 1200; i++) begin
      if (q.size() == 100) break;
      if (q.size() > 100) cyc(1'b0, '0, 1'b1);
      else                cyc(1'b1, rnd(), 1'b0);
    end
    chk("t6_occ_100", 128'(q.size()), 128'(100));
    #2 aresetn = 1'b0;
    #1;
    chk("t6_empty",   128'(bus.EMPTY),       128'(1));
    chk("t6_do",      128'(bus.DO),          128'(0));
    chk("t6_full",    128'(bus.FULL),        128'(0));
    chk("t6_af",      128'(bus.ALMOSTFULL),  128'(0));
    chk("t6_ae",      128'(bus.ALMOSTEMPTY), 128'(1));
    chk("t6_wrcount", 128'(bus.WRCOUNT),     128'(0));
    chk("t6_rdcount", 128'(bus.RDCOUNT),     128'(0));
    chk("t6_wrerr",   128'(bus.WRERR),       128'(0));
    chk("t6_rderr",   128'(bus.RDERR),       128'(0));
    @(posedge aclk);
    #3 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    cyc(1'b1, 72'hC5, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("t6_first_do",    128'(bus.DO),    128'(72'hC5));
    chk("t6_first_empty", 128'(bus.EMPTY), 128'(0));
    cyc(1'b0, '0, 1'b1);
    chk("t6_empty_end", 128'(bus.EMPTY), 128'(1));

    repeat (2) @(posedge aclk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
